// File: rtl/vca_pkg.sv
// Shared widths, saturation bounds and the round/saturate helper used by the VCA
// and the downstream mixer.
package vca_pkg;

    localparam int SAMPLE_W = 16;
    localparam int ENV_W    = 16;
    localparam int PROD_W   = SAMPLE_W + ENV_W + 1;

    localparam logic signed [SAMPLE_W-1:0] SAT_HI = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [SAMPLE_W-1:0] SAT_LO = {1'b1, {(SAMPLE_W-1){1'b0}}};

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] sample;
        logic                       sat;
    } sat_t;

    // Half-LSB of the output scale, added before the arithmetic shift for round half-up.
    function automatic logic signed [PROD_W-1:0] round_const(input int shift);
        return PROD_W'(1) << (shift - 1);
    endfunction

    function automatic sat_t sat_round(input logic signed [PROD_W-1:0] prod, input int shift);
        logic signed [PROD_W:0] r;
        sat_t                   res;
        r = (PROD_W+1)'(prod) + (PROD_W+1)'(round_const(shift));
        r = r >>> shift;
        res.sat = 1'b1;
        if (r > (PROD_W+1)'(SAT_HI))
            res.sample = SAT_HI;
        else if (r < (PROD_W+1)'(SAT_LO))
            res.sample = SAT_LO;
        else begin
            res.sample = r[SAMPLE_W-1:0];
            res.sat    = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/gain_slew.sv
// Slew limiter: gain chases target by at most SLEW_MAX per clock, landing exactly
// on target once within reach, so it can neither overshoot nor wrap.
module gain_slew #(
    parameter int ENV_W    = 16,
    parameter int SLEW_MAX = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ENV_W-1:0] target,
    output logic [ENV_W-1:0] gain
);

    localparam logic [ENV_W-1:0] STEP = ENV_W'(SLEW_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            gain <= '0;
        else if (target > gain)
            gain <= (target - gain > STEP) ? gain + STEP : target;
        else
            gain <= (gain - target > STEP) ? gain - STEP : target;
    end

endmodule

// File: rtl/envelope_vca.sv
// VCA: two-stage multiply / round-saturate pipeline with valid/ready backpressure,
// gain slewed toward the envelope and a sticky clip flag.
module envelope_vca
    import vca_pkg::*;
#(
    parameter int SLEW_MAX   = 1024,
    parameter int GAIN_SHIFT = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic signed [SAMPLE_W-1:0] s_sample,
    input  logic        [ENV_W-1:0]    envelope,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic signed [SAMPLE_W-1:0] m_sample,
    output logic        [ENV_W-1:0]    gain,
    output logic                       clip,
    input  logic                       clip_clear
);

    localparam int RSHIFT = ENV_W - GAIN_SHIFT;

    logic [2:1]               vld_pipe;
    logic signed [PROD_W-1:0] prod;
    logic                     adv1, adv2;
    sat_t                     sr;

    gain_slew #(.ENV_W(ENV_W), .SLEW_MAX(SLEW_MAX)) u_slew (
        .clk    (clk),
        .reset  (reset),
        .target (envelope),
        .gain   (gain)
    );

    // A stage may load when it is empty or its contents are leaving this cycle.
    assign adv2    = !vld_pipe[2] || m_ready;
    assign adv1    = !vld_pipe[1] || adv2;
    assign s_ready = adv1;
    assign m_valid = vld_pipe[2];
    assign sr      = sat_round(prod, RSHIFT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
            prod     <= '0;
            m_sample <= '0;
            clip     <= 1'b0;
        end else begin
            if (adv1)
                vld_pipe[1] <= s_valid;
            // Uses the pre-update gain, i.e. the value present in the accept cycle.
            if (adv1 && s_valid)
                prod <= PROD_W'(s_sample) * PROD_W'($signed({1'b0, gain}));
            if (adv2)
                vld_pipe[2] <= vld_pipe[1];
            if (adv2 && vld_pipe[1])
                m_sample <= sr.sample;
            if (adv2 && vld_pipe[1] && sr.sat)
                clip <= 1'b1;
            else if (clip_clear)
                clip <= 1'b0;
        end
    end

endmodule

// File: tb/tb_envelope_vca.sv
// Bench for envelope_vca: directed steps plus random samples/envelopes, scored
// against an arithmetic model of gain slew and scaled, rounded, clamped output.
module tb_envelope_vca;

    logic               clk = 1'b0;
    logic               reset;
    logic               s_valid, m_ready, clip_clear;
    logic signed [15:0] s_sample;
    logic        [15:0] envelope;

    logic               s_ready0, m_valid0, clip0, s_ready1, m_valid1, clip1;
    logic signed [15:0] m_sample0, m_sample1;
    logic        [15:0] gain0, gain1;

    envelope_vca #(.SLEW_MAX(1024), .GAIN_SHIFT(0)) dut0 (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready0),
        .s_sample(s_sample), .envelope(envelope), .m_valid(m_valid0),
        .m_ready(m_ready), .m_sample(m_sample0), .gain(gain0), .clip(clip0),
        .clip_clear(clip_clear)
    );

    envelope_vca #(.SLEW_MAX(1024), .GAIN_SHIFT(1)) dut1 (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready1),
        .s_sample(s_sample), .envelope(envelope), .m_valid(m_valid1),
        .m_ready(m_ready), .m_sample(m_sample1), .gain(gain1), .clip(clip1),
        .clip_clear(clip_clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [63:0] v0;
        logic signed [63:0] v1;
        int                 t;
    } item_t;

    item_t              q[$];
    logic signed [63:0] got0[$], got1[$];
    int                 g, cyc;
    int                 n_pass = 0, n_total = 0;
    bit                 acc, held_v, saw_stall;
    logic signed [63:0] held;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Ideal output: round(sample*gain / 2^k) with ties toward +inf, clamped to 16 bits.
    function automatic logic signed [63:0] ref_out(input int s, input int gg, input int k);
        real r;
        r = $floor(real'(s) * real'(gg) / (2.0 ** k) + 0.5);
        if (r > 32767.0) r = 32767.0;
        if (r < -32768.0) r = -32768.0;
        return 64'($rtoi(r));
    endfunction

    function automatic int ref_slew(input int cur, input int tgt);
        int d;
        d = tgt - cur;
        if (d > 1024) d = 1024;
        if (d < -1024) d = -1024;
        return cur + d;
    endfunction

    function automatic logic signed [63:0] got_at(input int i);
        return (i < got0.size()) ? got0[i] : 'x;
    endfunction

    // One clock: inputs were set by the caller at the negedge; check, then model the edge.
    task automatic cycle();
        #1;
        check("s_ready", s_ready0, (q.size() < 2) || m_ready);
        check("s_ready_gs1", s_ready1, (q.size() < 2) || m_ready);
        check("m_valid", m_valid0, (q.size() > 0) ? (cyc >= q[0].t + 2) : 1'b0);
        check("gain", gain0, g);
        if (held_v) begin
            check("stall_valid", m_valid0, 1'b1);
            check("stall_hold", m_sample0, held);
        end
        if (!s_ready0) saw_stall = 1'b1;
        if (m_valid0 && m_ready) begin
            if (q.size() > 0) begin
                check("m_sample", m_sample0, q[0].v0);
                check("m_sample_gs1", m_sample1, q[0].v1);
                void'(q.pop_front());
            end
            got0.push_back(m_sample0);
            got1.push_back(m_sample1);
        end
        held_v = m_valid0 && !m_ready;
        held   = m_sample0;
        acc    = s_valid && s_ready0;
        if (acc)
            q.push_back('{ref_out(int'(s_sample), g, 16), ref_out(int'(s_sample), g, 15), cyc});
        @(posedge clk);
        cyc++;
        g = ref_slew(g, int'(envelope));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic send(input int s);
        s_valid = 1'b1;
        s_sample = 16'(s);
        cycle();
        s_valid = 1'b0;
    endtask

    initial begin
        int idx;
        logic signed [15:0] bp [6];

        // Reset held with live inputs.
        reset = 1'b0; clip_clear = 1'b0; s_valid = 1'b1; s_sample = 16'sd1234;
        envelope = 16'hFFFF; m_ready = 1'b1;
        g = 0; cyc = 0; held_v = 1'b0; saw_stall = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_m_valid", m_valid0, 1'b0);
        check("rst_gain", gain0, 0);
        check("rst_clip", clip0, 1'b0);
        check("rst_s_ready", s_ready0, 1'b1);
        check("rst_m_sample", m_sample0, 0);
        check("rst_m_valid_gs1", m_valid1, 1'b0);
        s_valid = 1'b0; envelope = 16'd0; reset = 1'b1;
        idle(2);

        // Slew from 0 toward full scale.
        envelope = 16'hFFFF;
        for (int k = 1; k <= 70; k++) begin
            cycle();
            check("slew_k", gain0, (k * 1024 > 65535) ? 65535 : k * 1024);
        end

        // Steady gain of one half.
        envelope = 16'd32768;
        idle(40);
        got0.delete();
        send(20000); send(-20000); send(1);
        idle(4);
        check("steady_count", got0.size(), 3);
        check("steady_0", got_at(0), 10000);
        check("steady_1", got_at(1), -10000);
        check("steady_2", got_at(2), 1);

        // Rounding half-up.
        got0.delete();
        send(-3); send(3); send(-32768);
        idle(4);
        check("round_m3", got_at(0), -1);
        check("round_p3", got_at(1), 2);
        check("round_min", got_at(2), -16384);

        // Backpressure burst with random samples and a moving envelope.
        got0.delete();
        foreach (bp[i]) bp[i] = 16'($urandom);
        idx = 0; saw_stall = 1'b0;
        for (int c = 0; c < 30; c++) begin
            s_valid  = idx < 6;
            s_sample = bp[idx % 6];
            m_ready  = !(c >= 2 && c < 7);
            envelope = 16'($urandom_range(65535));
            cycle();
            if (acc) idx++;
        end
        s_valid = 1'b0; m_ready = 1'b1;
        check("bp_count", got0.size(), 6);
        check("bp_stalled", saw_stall, 1'b1);

        // Clip on the headroom instance.
        envelope = 16'hFFFF;
        idle(70);
        got1.delete();
        send(30000);
        idle(3);
        check("clip_val", (got1.size() > 0) ? got1[0] : 'x, 32767);
        check("clip_set", clip1, 1'b1);
        check("clip_none_gs0", clip0, 1'b0);
        clip_clear = 1'b1;
        cycle();
        clip_clear = 1'b0;
        check("clip_cleared", clip1, 1'b0);
        send(-30000);
        clip_clear = 1'b1;
        cycle();
        clip_clear = 1'b0;
        check("clip_set_wins", clip1, 1'b1);
        idle(3);

        // Reset asserted mid-burst drops m_valid without a clock edge.
        envelope = 16'd32768;
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_sample = 16'($urandom);
            cycle();
        end
        check("burst_valid", m_valid0, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("async_m_valid", m_valid0, 1'b0);
        check("async_m_valid_gs1", m_valid1, 1'b0);
        check("async_gain", gain0, 0);
        check("async_clip", clip1, 1'b0);
        @(negedge clk);
        s_valid = 1'b0; reset = 1'b1;
        q.delete(); g = 0; held_v = 1'b0;
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
